// File: rtl/sar_search3.sv
// sar_search3: successive-approximation search of a hidden operand through an external comparator.
// Optional flag/step checking with err pulse is compiled in by defining SAR_ERR_CHECK_EN.
module sar_search3 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         y0,
  input  logic         y1,
  input  logic         y2,
  output logic [W-1:0] guess,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_PROBE  = 2'd1;
  localparam logic [1:0]    S_FIN    = 2'd2;
  localparam int            SW       = $clog2(W + 2);
  localparam logic [W-1:0]  MAXV     = {W{1'b1}};
  localparam logic [SW-1:0] STEP_LIM = SW'(W + 1);

  logic [1:0]    state_q,  state_d;
  logic [W-1:0]  lo_q,     lo_d;
  logic [W-1:0]  hi_q,     hi_d;
  logic [W-1:0]  guess_q,  guess_d;
  logic [W-1:0]  result_q, result_d;
  logic [SW-1:0] step_q,   step_d;
  logic          fail_q,   fail_d;

  logic          hit, up, fail;
  logic [SW-1:0] step_inc;
  logic [W-1:0]  lo_up, hi_dn;
  logic [W:0]    sum_up, sum_dn;

  assign step_inc = (step_q == STEP_LIM) ? step_q : step_q + 1'b1;
  assign lo_up    = (guess_q == MAXV) ? MAXV : guess_q + 1'b1;
  assign hi_dn    = (guess_q == '0) ? '0 : guess_q - 1'b1;
  assign sum_up   = {1'b0, lo_up} + {1'b0, hi_q};
  assign sum_dn   = {1'b0, lo_q} + {1'b0, hi_dn};

`ifdef SAR_ERR_CHECK_EN
  logic onehot;
  assign onehot = ({y0, y1, y2} == 3'b100) || ({y0, y1, y2} == 3'b010) ||
                  ({y0, y1, y2} == 3'b001);
  assign hit    = onehot && y1;
  assign up     = onehot && y0;
  assign fail   = !onehot || (!y1 && (step_inc == STEP_LIM));
`else
  // y1 > y0 > y2; anything else (including all-zero) moves down.
  assign hit    = y1;
  assign up     = !y1 && y0;
  assign fail   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      step_q   <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      step_q   <= step_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    step_d   = step_q;
    fail_d   = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PROBE;
          lo_d    = '0;
          hi_d    = MAXV;
          guess_d = MAXV >> 1;
          step_d  = '0;
          fail_d  = 1'b0;
        end
      end
      S_PROBE: begin
        step_d = step_inc;
        if (fail) begin
          state_d = S_FIN;
          fail_d  = 1'b1;
        end else if (hit) begin
          state_d  = S_FIN;
          result_d = guess_q;
        end else if (up) begin
          lo_d    = lo_up;
          guess_d = sum_up[W:1];
        end else begin
          hi_d    = hi_dn;
          guess_d = sum_dn[W:1];
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    guess  = guess_q;
    result = result_q;
    busy   = (state_q == S_PROBE);
    done   = (state_q == S_FIN) && !fail_q;
`ifdef SAR_ERR_CHECK_EN
    err    = (state_q == S_FIN) && fail_q;
`else
    err    = 1'b0;
`endif
  end

endmodule
